// File: rtl/pipe_pkg.sv
// Shared definitions for the inter-stage pipeline registers: per-boundary widths
// and control-bit positions so that gating and downstream decode agree.
package pipe_pkg;

    localparam int OCC_W = 2;

    localparam int RD_EX_DATA_W  = 160;
    localparam int RD_EX_CTRL_W  = 16;
    localparam int EX_MEM_DATA_W = 106;
    localparam int EX_MEM_CTRL_W = 8;
    localparam int MEM_WB_DATA_W = 69;
    localparam int MEM_WB_CTRL_W = 4;

    // Bit positions inside the control vector; downstream decode uses the same indices.
    localparam int CTRL_REGWRITE  = 0;
    localparam int CTRL_MEMREAD   = 1;
    localparam int CTRL_MEMWRITE  = 2;
    localparam int CTRL_MEMTOREG  = 3;
    localparam int CTRL_BRANCH    = 4;
    localparam int CTRL_ALUSRC    = 5;
    localparam int CTRL_ALUOP_LSB = 6;
    localparam int CTRL_ALUOP_W   = 4;
    localparam int CTRL_REGDST    = 10;

    typedef enum logic [1:0] {
        BND_RD_EX  = 2'd0,
        BND_EX_MEM = 2'd1,
        BND_MEM_WB = 2'd2
    } boundary_e;

    function automatic int data_w_of(input boundary_e b);
        case (b)
            BND_RD_EX:  return RD_EX_DATA_W;
            BND_EX_MEM: return EX_MEM_DATA_W;
            default:    return MEM_WB_DATA_W;
        endcase
    endfunction

    function automatic int ctrl_w_of(input boundary_e b);
        case (b)
            BND_RD_EX:  return RD_EX_CTRL_W;
            BND_EX_MEM: return EX_MEM_CTRL_W;
            default:    return MEM_WB_CTRL_W;
        endcase
    endfunction

endpackage

// File: rtl/pipe_entry_reg.sv
// Single pipeline entry: valid flag plus payload and control storage.
// Storage only writes on load, so bubbles never toggle the data flops.
module pipe_entry_reg #(
    parameter int DATA_W = 64,
    parameter int CTRL_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic              clear,
    input  logic [DATA_W-1:0] d_data,
    input  logic [CTRL_W-1:0] d_ctrl,
    output logic              valid,
    output logic [DATA_W-1:0] q_data,
    output logic [CTRL_W-1:0] q_ctrl
);

    // load wins over clear so a drain-and-refill in one cycle keeps the entry valid
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid  <= 1'b0;
            q_data <= '0;
            q_ctrl <= '0;
        end else begin
            if (load)
                valid <= 1'b1;
            else if (clear)
                valid <= 1'b0;
            if (load) begin
                q_data <= d_data;
                q_ctrl <= d_ctrl;
            end
        end
    end

endmodule

// File: rtl/pipe_stage_reg.sv
// Inter-stage pipeline register with valid/ready flow control, flush and an
// optional skid entry that makes in_ready a pure flop output.
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int DATA_W = 64,
    parameter int CTRL_W = 16,
    parameter int SKID   = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [OCC_W-1:0]  occupancy
);

    logic              main_v;
    logic [DATA_W-1:0] main_data;
    logic [CTRL_W-1:0] main_ctrl;
    logic              main_load;
    logic              main_clear;
    logic [DATA_W-1:0] main_d_data;
    logic [CTRL_W-1:0] main_d_ctrl;
    logic              skid_v;
    logic              in_xfer;
    logic              main_drain;

    assign in_xfer    = in_valid & in_ready;
    assign main_drain = main_v & out_ready;

    pipe_entry_reg #(
        .DATA_W (DATA_W),
        .CTRL_W (CTRL_W)
    ) u_main (
        .clk    (clk),
        .rst_n  (rst_n),
        .load   (main_load),
        .clear  (main_clear),
        .d_data (main_d_data),
        .d_ctrl (main_d_ctrl),
        .valid  (main_v),
        .q_data (main_data),
        .q_ctrl (main_ctrl)
    );

    generate
        if (SKID != 0) begin : g_skid
            logic              skid_load;
            logic              skid_clear;
            logic [DATA_W-1:0] skid_data;
            logic [CTRL_W-1:0] skid_ctrl;

            pipe_entry_reg #(
                .DATA_W (DATA_W),
                .CTRL_W (CTRL_W)
            ) u_skid (
                .clk    (clk),
                .rst_n  (rst_n),
                .load   (skid_load),
                .clear  (skid_clear),
                .d_data (in_data),
                .d_ctrl (in_ctrl),
                .valid  (skid_v),
                .q_data (skid_data),
                .q_ctrl (skid_ctrl)
            );

            // in_ready comes straight from the skid valid flop
            assign in_ready = !skid_v;

            always_comb begin
                main_load   = 1'b0;
                main_clear  = 1'b0;
                main_d_data = in_data;
                main_d_ctrl = in_ctrl;
                skid_load   = 1'b0;
                skid_clear  = 1'b0;
                if (flush) begin
                    main_clear = 1'b1;
                    skid_clear = 1'b1;
                end else begin
                    if (main_drain && skid_v) begin
                        main_load   = 1'b1;
                        main_d_data = skid_data;
                        main_d_ctrl = skid_ctrl;
                        skid_clear  = 1'b1;
                    end else if (in_xfer && (!main_v || main_drain)) begin
                        main_load = 1'b1;
                    end else if (main_drain) begin
                        main_clear = 1'b1;
                    end
                    if (in_xfer && main_v && !main_drain)
                        skid_load = 1'b1;
                end
            end
        end else begin : g_single
            assign skid_v   = 1'b0;
            assign in_ready = !main_v || out_ready;

            always_comb begin
                main_d_data = in_data;
                main_d_ctrl = in_ctrl;
                main_load   = in_xfer && !flush;
                main_clear  = flush || main_drain;
            end
        end
    endgenerate

    assign out_valid = main_v;
    assign out_data  = main_data;
    assign out_ctrl  = main_ctrl & {CTRL_W{main_v}};
    assign occupancy = {1'b0, main_v} + {1'b0, skid_v};

    // A stalled head entry must not change until it is taken
    a_stall_stable: assert property (
        @(posedge clk) disable iff (!rst_n)
        (out_valid && !out_ready && !flush) |=>
            (out_valid && $stable(out_data) && $stable(out_ctrl))
    );

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed and randomised checks of pipe_stage_reg with both SKID settings
// driven from the same upstream/downstream stimulus.
module tb_pipe_stage_reg;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        out_ready;
    logic [15:0] in_data;
    logic [15:0] in_ctrl;

    logic        r0, v0, r1, v1;
    logic [15:0] d0, c0, d1, c1;
    logic [1:0]  o0, o1;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    pipe_stage_reg #(.DATA_W(16), .CTRL_W(16), .SKID(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(r0), .in_data(in_data), .in_ctrl(in_ctrl),
        .out_valid(v0), .out_ready(out_ready), .out_data(d0), .out_ctrl(c0),
        .occupancy(o0)
    );

    pipe_stage_reg #(.DATA_W(16), .CTRL_W(16), .SKID(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(r1), .in_data(in_data), .in_ctrl(in_ctrl),
        .out_valid(v1), .out_ready(out_ready), .out_data(d1), .out_ctrl(c1),
        .occupancy(o1)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b1; in_valid = 1'b1; in_data = 16'h1234; in_ctrl = 16'h00F0; out_ready = 1'b0;
        step();
        total++; if (v1 !== 1'b1 || d1 !== 16'h1234) begin bad++; $display("FAIL pre_reset_load got v=%0h d=%0h exp v=1 d=1234", v1, d1); end
        #3 rst_n = 1'b0;
        #1;
        total++; if ({v0, v1} !== 2'b00) begin bad++; $display("FAIL rst_valid got=%0b exp=00", {v0, v1}); end
        total++; if ({d0, d1} !== 32'h0) begin bad++; $display("FAIL rst_data got=%0h exp=0", {d0, d1}); end
        total++; if ({c0, c1} !== 32'h0) begin bad++; $display("FAIL rst_ctrl got=%0h exp=0", {c0, c1}); end
        total++; if ({o0, o1} !== 4'h0) begin bad++; $display("FAIL rst_occ got=%0h exp=0", {o0, o1}); end
        total++; if ({r0, r1} !== 2'b11) begin bad++; $display("FAIL rst_in_ready got=%0b exp=11", {r0, r1}); end
        in_valid = 1'b0;
        step(); step();
        rst_n = 1'b1;
        step();
        total++; if ({r0, r1, v0, v1, o0, o1} !== 8'b1100_0000) begin bad++; $display("FAIL post_release got=%0b exp=11000000", {r0, r1, v0, v1, o0, o1}); end
    endtask

    task automatic test_stream();
        out_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            in_valid = 1'b1; in_data = 16'(i); in_ctrl = 16'h0100 | 16'(i);
            step();
            total++; if (v0 !== 1'b1 || d0 !== 16'(i) || c0 !== (16'h0100 | 16'(i))) begin bad++; $display("FAIL stream0_%0d got v=%0h d=%0h c=%0h exp v=1 d=%0h", i, v0, d0, c0, i); end
            total++; if (v1 !== 1'b1 || d1 !== 16'(i) || o1 !== 2'd1) begin bad++; $display("FAIL stream1_%0d got v=%0h d=%0h occ=%0d exp v=1 d=%0h occ=1", i, v1, d1, o1, i); end
        end
        in_valid = 1'b0;
        step();
        total++; if ({v0, v1} !== 2'b00) begin bad++; $display("FAIL stream_empty got=%0b exp=00", {v0, v1}); end
    endtask

    task automatic test_skid_stall();
        out_ready = 1'b0; in_valid = 1'b1; in_data = 16'hAAAA; in_ctrl = 16'h000A;
        step();
        total++; if (o1 !== 2'd1 || r1 !== 1'b1) begin bad++; $display("FAIL skid_one got occ=%0d rdy=%0b exp occ=1 rdy=1", o1, r1); end
        in_data = 16'hBBBB; in_ctrl = 16'h000B;
        step();
        total++; if (o1 !== 2'd2 || r1 !== 1'b0 || d1 !== 16'hAAAA) begin bad++; $display("FAIL skid_full got occ=%0d rdy=%0b d=%0h exp occ=2 rdy=0 d=aaaa", o1, r1, d1); end
        in_data = 16'hCCCC; in_ctrl = 16'h000C;
        step();
        total++; if (o1 !== 2'd2 || d1 !== 16'hAAAA || c1 !== 16'h000A) begin bad++; $display("FAIL skid_hold got occ=%0d d=%0h c=%0h exp occ=2 d=aaaa c=a", o1, d1, c1); end
        out_ready = 1'b1;
        #1;
        total++; if (d1 !== 16'hAAAA || v1 !== 1'b1) begin bad++; $display("FAIL skid_out_a got d=%0h v=%0b exp d=aaaa v=1", d1, v1); end
        step();
        total++; if (d1 !== 16'hBBBB || o1 !== 2'd1 || r1 !== 1'b1) begin bad++; $display("FAIL skid_out_b got d=%0h occ=%0d rdy=%0b exp d=bbbb occ=1 rdy=1", d1, o1, r1); end
        step();
        total++; if (d1 !== 16'hCCCC || c1 !== 16'h000C || o1 !== 2'd1) begin bad++; $display("FAIL skid_out_c got d=%0h c=%0h occ=%0d exp d=cccc c=c occ=1", d1, c1, o1); end
        in_valid = 1'b0;
        step();
        total++; if (v1 !== 1'b0 || o1 !== 2'd0) begin bad++; $display("FAIL skid_drained got v=%0b occ=%0d exp v=0 occ=0", v1, o1); end
    endtask

    task automatic test_flush();
        out_ready = 1'b0; in_valid = 1'b1; in_data = 16'h1111; in_ctrl = 16'hFFFF;
        step();
        in_data = 16'h2222;
        step();
        total++; if (o1 !== 2'd2) begin bad++; $display("FAIL flush_pre_occ got=%0d exp=2", o1); end
        in_data = 16'hDDDD; flush = 1'b1;
        step();
        flush = 1'b0; in_valid = 1'b0;
        #1;
        total++; if ({v0, v1} !== 2'b00 || {o0, o1} !== 4'h0) begin bad++; $display("FAIL flush_clear got v=%0b occ=%0h exp v=00 occ=0", {v0, v1}, {o0, o1}); end
        total++; if ({c0, c1} !== 32'h0 || {r0, r1} !== 2'b11) begin bad++; $display("FAIL flush_ctrl got c=%0h rdy=%0b exp c=0 rdy=11", {c0, c1}, {r0, r1}); end
        total++; if (d1 !== 16'h1111) begin bad++; $display("FAIL flush_data_hold got=%0h exp=1111", d1); end
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            total++; if ({v0, v1} !== 2'b00 || d1 === 16'hDDDD || d0 === 16'hDDDD) begin bad++; $display("FAIL flush_leak_%0d got v=%0b d0=%0h d1=%0h exp v=00 no dddd", i, {v0, v1}, d0, d1); end
        end
    endtask

    task automatic test_gating();
        out_ready = 1'b1; in_valid = 1'b0; in_ctrl = 16'hFFFF; in_data = 16'h5555;
        step(); step();
        total++; if ({c0, c1} !== 32'h0 || {v0, v1} !== 2'b00) begin bad++; $display("FAIL gate_bubble got c=%0h v=%0b exp c=0 v=00", {c0, c1}, {v0, v1}); end
        in_valid = 1'b1;
        step();
        total++; if (c0 !== 16'hFFFF || c1 !== 16'hFFFF || d1 !== 16'h5555) begin bad++; $display("FAIL gate_pass got c0=%0h c1=%0h d1=%0h exp ffff ffff 5555", c0, c1, d1); end
        in_valid = 1'b0;
        step();
        total++; if ({c0, c1} !== 32'h0 || d0 !== 16'h5555 || d1 !== 16'h5555) begin bad++; $display("FAIL gate_after got c=%0h d0=%0h d1=%0h exp c=0 d=5555", {c0, c1}, d0, d1); end
    endtask

    task automatic test_random();
        logic [15:0] q0[$];
        logic [15:0] q1[$];
        logic [15:0] seq = 16'h0100;
        logic        pv0 = 1'b0, pr0 = 1'b0, pv1 = 1'b0, pr1 = 1'b0;
        logic [15:0] pd0 = '0, pc0 = '0, pd1 = '0, pc1 = '0;
        logic [15:0] exp_d;
        for (int n = 0; n < 10040; n++) begin
            if (n < 10000) begin
                in_valid  = 1'($urandom_range(0, 1));
                out_ready = ($urandom_range(0, 3) != 0);
            end else begin
                in_valid  = 1'b0;
                out_ready = 1'b1;
            end
            seq     = seq + 16'd1;
            in_data = seq;
            in_ctrl = ~seq;
            #4;
            if (pv0 && !pr0) begin
                total++; if (!v0 || d0 !== pd0 || c0 !== pc0) begin bad++; $display("FAIL rnd_stable0 n=%0d got v=%0b d=%0h c=%0h exp v=1 d=%0h c=%0h", n, v0, d0, c0, pd0, pc0); end
            end
            if (pv1 && !pr1) begin
                total++; if (!v1 || d1 !== pd1 || c1 !== pc1) begin bad++; $display("FAIL rnd_stable1 n=%0d got v=%0b d=%0h c=%0h exp v=1 d=%0h c=%0h", n, v1, d1, c1, pd1, pc1); end
            end
            if (v0 && out_ready) begin
                exp_d = (q0.size() > 0) ? q0.pop_front() : 16'hxxxx;
                total++; if (d0 !== exp_d || c0 !== ~exp_d) begin bad++; $display("FAIL rnd_order0 n=%0d got d=%0h c=%0h exp d=%0h", n, d0, c0, exp_d); end
            end
            if (v1 && out_ready) begin
                exp_d = (q1.size() > 0) ? q1.pop_front() : 16'hxxxx;
                total++; if (d1 !== exp_d || c1 !== ~exp_d) begin bad++; $display("FAIL rnd_order1 n=%0d got d=%0h c=%0h exp d=%0h", n, d1, c1, exp_d); end
            end
            if (in_valid && r0) q0.push_back(in_data);
            if (in_valid && r1) q1.push_back(in_data);
            pv0 = v0; pr0 = out_ready; pd0 = d0; pc0 = c0;
            pv1 = v1; pr1 = out_ready; pd1 = d1; pc1 = c1;
            step();
        end
        total++; if (q0.size() != 0 || q1.size() != 0 || v0 || v1) begin bad++; $display("FAIL rnd_drain got q0=%0d q1=%0d v=%0b exp 0 0 00", q0.size(), q1.size(), {v0, v1}); end
    endtask

    initial begin
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_data = '0; in_ctrl = '0;
        step(); step();
        test_reset();
        test_stream();
        test_skid_stall();
        test_flush();
        test_gating();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
Parametrised inter-stage pipeline register, successor to the fixed-field stage latches between RD/EX/MEM/WB.
- Carries an opaque datapath payload plus a separate control-bit vector.
- Adds valid/ready flow control, stall by back-pressure, flush (bubble insertion), optional skid entry for timing-clean ready, and control-bit gating so a bubble can never assert regwrite/memwrite downstream.
- One instance per pipeline boundary; widths set per boundary.

Parameters:
DATA_W, 64, payload width in bits (npc, pc, operands, immediates, regdst, ...); must be ≥1.
CTRL_W, 16, control-bit vector width (regwrite, memread, aluop, ...); must be ≥1.
SKID, 1, 0 = single entry with combinational in_ready; 1 = main + skid entry with registered in_ready.

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
flush  input  1  squash all held entries (branch/jump redirect)
in_valid  input  1  upstream presents an entry
in_ready  output  1  stage can accept this cycle
in_data  input  DATA_W  upstream payload
in_ctrl  input  CTRL_W  upstream control bits
out_valid  output  1  downstream entry valid
out_ready  input  1  downstream accepts this cycle
out_data  output  DATA_W  payload of head entry
out_ctrl  output  CTRL_W  control bits of head entry, forced 0 when out_valid=0
occupancy  output  2  entries held (0..1 for SKID=0, 0..2 for SKID=1)

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous, active-low on rst_n.
- Reset values: all valid flags 0; all data/ctrl storage 0; out_valid=0; out_ctrl=0; out_data=0; occupancy=0; in_ready=1. Reset mid-transfer discards everything; no partial state survives.
- Transfers:
  - In-transfer = in_valid & in_ready at a rising edge.
  - Out-transfer = out_valid & out_ready at a rising edge.
- Latency: 1 cycle. An entry accepted at edge N is visible on out_* after edge N. Full throughput of 1 entry/cycle when out_ready is held high.
- SKID=0:
  - in_ready = !out_valid | out_ready (combinational).
  - An in-transfer loads main.
  - An out-transfer without an in-transfer clears main valid.
- SKID=1:
  - in_ready = !skid_valid, registered.
  - Main empty, or main draining this cycle: an in-transfer loads main.
  - Main full and not draining: an in-transfer loads skid.
  - Skid refills main on an out-transfer.
  - Ordering is strictly FIFO.
- Stall: out_ready=0 holds out_data/out_ctrl/out_valid stable until the out-transfer. Stability is a checked property.
- Flush:
  - At the edge where flush=1, all valid flags clear.
  - Any in-transfer in that same cycle is discarded (flush wins).
  - Next cycle: out_valid=0, occupancy=0, in_ready=1.
- Gating: out_ctrl = ctrl_reg & {CTRL_W{out_valid}}. out_data is not gated and holds its last loaded value. Data/ctrl storage only writes on load (no toggling on bubbles).
- occupancy = main_valid + skid_valid.
- Simultaneous in- and out-transfer with SKID=1 and both entries full cannot occur, because in_ready=0.

Decomposition:
- Shared package pipe_pkg:
  - per-boundary width constants (RD_EX_DATA_W, RD_EX_CTRL_W, EX_MEM_*, MEM_WB_*);
  - control-bit index constants (CTRL_REGWRITE, CTRL_MEMWRITE, ...) so gating and decode agree.
- One natural sub-module: pipe_entry_reg, a single valid+data+ctrl register with load/clear. It is instantiated once (SKID=0) or twice (SKID=1).

Test Plan:
- Reset release with rst_n low mid-cycle -> all outputs 0 immediately (async); in_ready=1 after release; occupancy=0.
- Stream 8 entries, in_data=0x0001..0x0008, out_ready=1 -> out_data 0x0001..0x0008 on consecutive cycles, 1-cycle latency, no gaps, both SKID values.
- SKID=1, out_ready=0 while sending 0xAAAA then 0xBBBB -> occupancy 2, in_ready=0; third entry 0xCCCC held upstream; out_ready=1 -> outputs AAAA, BBBB, CCCC in order.
- Flush while occupancy=2 and in_valid=1 with 0xDDDD -> next cycle out_valid=0, occupancy=0, out_ctrl=0; 0xDDDD never appears at output.
- Bubble gating: in_ctrl=0xFFFF with in_valid=0 -> out_ctrl stays 0x0000; with in_valid=1 -> out_ctrl=0xFFFF after 1 cycle.
- Random in_valid/out_ready for 10k cycles vs scoreboard FIFO -> no loss, duplication or reordering; outputs stable while out_valid & !out_ready.
